// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF/ON/BLINK/ONESHOT driven by a shared tick.
// Optional PWM dimming is enabled with the LED_DIM_EN macro (adds dim_level input).

module led_chan #(
    parameter int PER_W        = 16,
    parameter int DEFAULT_HALF = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [1:0]       mode_in,
    input  logic [PER_W-1:0] half_in,
    input  logic             restart,
    input  logic             tick,
    output logic             led,
    output logic             busy
);
    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_ONESHOT} mode_t;

    mode_t            mode, mode_n;
    logic [PER_W-1:0] half, half_n, cnt, cnt_n, last;
    logic             led_n;

    // A zero half-period behaves as one tick.
    assign last = (half == '0) ? '0 : half - PER_W'(1);
    assign busy = (mode == M_ONESHOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= M_OFF;
            half <= PER_W'(DEFAULT_HALF);
            cnt  <= '0;
            led  <= 1'b0;
        end else begin
            mode <= mode_n;
            half <= half_n;
            cnt  <= cnt_n;
            led  <= led_n;
        end
    end

    always_comb begin
        mode_n = mode;
        half_n = half;
        cnt_n  = cnt;
        led_n  = led;
        if (we) begin
            mode_n = mode_t'(mode_in);
            half_n = half_in;
            cnt_n  = '0;
            led_n  = (mode_in != 2'd0);
        end else if (restart && mode == M_BLINK) begin
            cnt_n = '0;
            led_n = 1'b1;
        end else if (tick) begin
            case (mode)
                M_BLINK: begin
                    if (cnt >= last) begin
                        cnt_n = '0;
                        led_n = ~led;
                    end else begin
                        cnt_n = cnt + PER_W'(1);
                    end
                end
                M_ONESHOT: begin
                    if (cnt >= last) begin
                        cnt_n  = '0;
                        led_n  = 1'b0;
                        mode_n = M_OFF;
                    end else begin
                        cnt_n = cnt + PER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module led_pattern_gen #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int NUM_LEDS     = 8,
    parameter int PER_W        = 16,
    parameter int DEFAULT_HALF = 500,
    localparam int SEL_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [1:0]          cfg_mode,
    input  logic [PER_W-1:0]    cfg_half,
    input  logic                restart,
`ifdef LED_DIM_EN
    input  logic [3:0]          dim_level,
`endif
    output logic [NUM_LEDS-1:0] busy,
    output logic [NUM_LEDS-1:0] leds
);
    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);

    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic [NUM_LEDS-1:0] led_state;

    assign tick = (presc == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PRE_W'(1);
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_chan #(.PER_W(PER_W), .DEFAULT_HALF(DEFAULT_HALF)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (cfg_we && (cfg_sel == SEL_W'(i))),
            .mode_in (cfg_mode),
            .half_in (cfg_half),
            .restart (restart),
            .tick    (tick),
            .led     (led_state[i]),
            .busy    (busy[i])
        );
    end

`ifdef LED_DIM_EN
    // 15-step PWM: dim_level 15 is always on, 0 is always off.
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            leds    <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
            leds    <= led_state & {NUM_LEDS{pwm_cnt < dim_level}};
        end
    end
`else
    assign leds = led_state;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed table, corner sequences and
// randomized traffic against a tick-count reference model.
module tb_led_pattern_gen;
    localparam int N  = 6;
    localparam int PW = 16;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          cfg_we = 0;
    logic [2:0]    cfg_sel = 0;
    logic [1:0]    cfg_mode = 0;
    logic [PW-1:0] cfg_half = 0;
    logic          restart = 0;
    logic [3:0]    dim_level = 4'd15;
    logic [N-1:0]  busy, leds;

    led_pattern_gen #(.CLK_FREQ(1000), .TICK_HZ(100), .NUM_LEDS(N),
                      .PER_W(PW), .DEFAULT_HALF(500)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .restart(restart),
`ifdef LED_DIM_EN
        .dim_level(dim_level),
`endif
        .busy(busy), .leds(leds));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Model: each channel remembers mode, half and ticks elapsed since it was
    // last (re)started; LED level follows from that count arithmetically.
    int m_mode[N], m_half[N], m_ts[N];
    int edges;
    logic [N-1:0] exp_leds;

    function automatic logic [N-1:0] model_state();
        logic [N-1:0] s = '0;
        for (int i = 0; i < N; i++) begin
            int h = (m_half[i] == 0) ? 1 : m_half[i];
            case (m_mode[i])
                1: s[i] = 1'b1;
                2: s[i] = ((m_ts[i] / h) % 2 == 0);
                3: s[i] = 1'b1;
                default: s[i] = 1'b0;
            endcase
        end
        return s;
    endfunction

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] b = '0;
        for (int i = 0; i < N; i++) b[i] = (m_mode[i] == 3);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0; m_half[i] = 500; m_ts[i] = 0;
        end
        edges = 0;
        exp_leds = '0;
    endtask

    task automatic model_edge(input logic we, input int sel, input int mode,
                              input int half, input logic rs, input int dim);
        logic [N-1:0] prev = model_state();
        logic tick;
        edges++;
        tick = (edges % 10 == 0);
        for (int i = 0; i < N; i++) begin
            int h = (m_half[i] == 0) ? 1 : m_half[i];
            if (we && sel == i) begin
                m_mode[i] = mode; m_half[i] = half; m_ts[i] = 0;
            end else if (rs && m_mode[i] == 2) begin
                m_ts[i] = 0;
            end else if (tick && m_mode[i] >= 2) begin
                m_ts[i]++;
                if (m_mode[i] == 3 && m_ts[i] >= h) m_mode[i] = 0;
            end
        end
`ifdef LED_DIM_EN
        exp_leds = prev & {N{((edges - 1) % 15) < dim}};
`else
        exp_leds = model_state();
        if (prev === 'x) exp_leds = 'x;
`endif
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, compare 1ns later.
    task automatic step(input logic we, input int sel, input int mode, input int half,
                        input logic rs);
        cfg_we = we; cfg_sel = 3'(sel); cfg_mode = 2'(mode);
        cfg_half = PW'(half); restart = rs;
        @(posedge clk);
        model_edge(we, sel, mode, half, rs, int'(dim_level));
        #1;
        check("model_leds", leds, exp_leds);
        check("model_busy", busy, model_busy());
        cfg_we = 0; restart = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic         we;
        int           sel, mode, half;
        logic         rs;
        logic [N-1:0] e_leds, e_busy;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int t0, t1, t2, e0, cntb;
        logic lv;
        // Edges 1..7 after reset: no tick yet, so every write shows up directly.
        vecs[0] = '{1, 0, 1, 9, 0, 6'b000001, 6'b000000};
        vecs[1] = '{1, 5, 3, 4, 0, 6'b100001, 6'b100000};
        vecs[2] = '{1, 6, 1, 1, 0, 6'b100001, 6'b100000};
        vecs[3] = '{1, 7, 2, 1, 0, 6'b100001, 6'b100000};
        vecs[4] = '{1, 2, 2, 0, 0, 6'b100101, 6'b100000};
        vecs[5] = '{1, 0, 0, 3, 0, 6'b100100, 6'b100000};
        vecs[6] = '{0, 0, 0, 0, 1, 6'b100100, 6'b100000};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_leds", leds, '0);
        check("reset_busy", busy, '0);
        rst_n = 1;

        for (int v = 0; v < 7; v++) begin
            step(vecs[v].we, vecs[v].sel, vecs[v].mode, vecs[v].half, vecs[v].rs);
`ifndef LED_DIM_EN
            check($sformatf("vec%0d_leds", v), leds, vecs[v].e_leds);
            check($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
`endif
        end
        // Edge 10 is the first tick: ch2 (half=0) must toggle off there.
        idle(2);
`ifndef LED_DIM_EN
        check("pre_tick_ch2", leds & 6'b000100, 6'b000100);
`endif
        idle(1);
        check_int("first_tick_edge", edges, 10);
`ifndef LED_DIM_EN
        check("first_tick_ch2", leds & 6'b000100, 6'b000000);
`endif
        idle(60);

        // BLINK half=3: every transition after the first is 30 clk apart.
        step(1, 0, 2, 3, 0);
        step(1, 2, 0, 1, 0);
        t0 = -1; t1 = -1; t2 = -1;
        lv = leds[0];
        for (int k = 0; k < 200 && t2 < 0; k++) begin
            step(0, 0, 0, 0, 0);
            if (leds[0] != lv) begin
                lv = leds[0];
                if (t0 < 0) t0 = edges; else if (t1 < 0) t1 = edges; else t2 = edges;
            end
        end
        check_int("blink_half_hi_lo", t1 - t0, 30);
        check_int("blink_half_lo_hi", t2 - t1, 30);

        // ONESHOT half=4: busy high until the 4th tick after the write, then stays low.
        step(1, 0, 0, 1, 0);
        step(1, 5, 3, 4, 0);
        e0 = edges;
        cntb = 1;
        for (int k = 0; k < 80 && busy[5]; k++) begin
            step(0, 0, 0, 0, 0);
            if (busy[5]) cntb++;
        end
        check_int("oneshot_len", cntb, (e0 / 10 + 4) * 10 - e0);
        idle(40);
        check("oneshot_done", {busy[5], leds[5]}, 2'b00);

        // Restart alignment of two out-of-phase BLINK channels.
        step(1, 1, 2, 2, 0);
        idle(13);
        step(1, 2, 2, 5, 0);
        idle(23);
        step(0, 0, 0, 0, 1);
`ifndef LED_DIM_EN
        check("restart_align", leds & 6'b000110, 6'b000110);
`endif
        idle(70);

        // Write to ch3 with restart, on a tick edge.
        for (int k = 0; k < 20 && (edges % 10) != 9; k++) step(0, 0, 0, 0, 0);
        check_int("tick_align", edges % 10, 9);
        step(1, 3, 2, 7, 1);
        idle(90);

        // Async reset mid-BLINK drops outputs without a clock edge.
        #2;
        rst_n = 0;
        #1;
        check("async_reset_leds", leds, '0);
        check("async_reset_busy", busy, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        idle(3);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic we = ($urandom % 5 == 0);
            step(we, int'($urandom % 8), int'($urandom % 4),
                 int'($urandom % 6), ($urandom % 23 == 0));
        end

`ifdef LED_DIM_EN
        for (int c = 0; c < N; c++) step(1, c, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        for (int d = 0; d < 3; d++) begin
            int lvl = (d == 0) ? 5 : (d == 1) ? 0 : 15;
            int hi = 0;
            dim_level = 4'(lvl);
            idle(2);
            for (int k = 0; k < 15; k++) begin
                step(0, 0, 0, 0, 0);
                if (leds[0]) hi++;
            end
            check_int($sformatf("dim_%0d_duty", lvl), hi, lvl);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
